tdm_mux_seq: RTL and testbench



---
 rtl/tdm_mux_seq.sv | 146 ++++++++++++++
 tb/tb_tdm_mux_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_seq.sv
// Registered N:1 TDM multiplexer with manual select and round-robin scan modes.
// Optional macro TDM_MUX_PARITY_EN adds the registered even-parity output Y_PAR.
module tdm_mux_seq #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  parameter int SW    = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N*W-1:0]  D,
  input  logic [SW-1:0]   SEL,
  input  logic            MODE,
  input  logic            EN,
  output logic [W-1:0]    Y,
  output logic            Y_VALID,
  output logic [SW-1:0]   CH,
  output logic            WRAP
`ifdef TDM_MUX_PARITY_EN
  ,
  output logic            Y_PAR
`endif
);

  localparam int            DW        = $clog2(DWELL + 1);
  localparam logic [SW-1:0] LAST_CH   = SW'(N - 1);
  localparam logic [DW-1:0] DWELL_CNT = DW'(DWELL);
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);

  typedef enum logic {
    ST_MAN  = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_y;
  logic           r_valid;
  logic [SW-1:0]  r_ch;
  logic           r_wrap;
  logic [DW-1:0]  r_dwell;

  logic [W-1:0]   w_y_nxt;
  logic           w_valid_nxt;
  logic [SW-1:0]  w_ch_nxt;
  logic           w_wrap_nxt;
  logic [DW-1:0]  w_dwell_nxt;
  logic           w_load;
  logic           w_sel_ok;
  logic [W-1:0]   w_ch_data [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_ch_data[g] = D[g*W +: W];
  end

  // SEL can only exceed N-1 when N is not a power of two.
  if (N == (1 << SW)) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_range
    assign w_sel_ok = (SEL < SW'(N));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_MAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_dwell counts enabled cycles already spent on r_ch, including the sample
  // taken on the cycle the channel was entered.
  always_comb begin
    w_state_nxt = MODE ? ST_SCAN : ST_MAN;
    w_y_nxt     = r_y;
    w_valid_nxt = 1'b0;
    w_ch_nxt    = r_ch;
    w_wrap_nxt  = 1'b0;
    w_dwell_nxt = r_dwell;
    w_load      = 1'b0;

    if (!MODE) begin
      w_dwell_nxt = '0;
      if (EN && w_sel_ok) begin
        w_ch_nxt = SEL;
        w_load   = 1'b1;
      end
    end else if (r_state == ST_MAN) begin
      w_ch_nxt    = '0;
      w_dwell_nxt = EN ? DWELL_ONE : '0;
      w_load      = EN;
    end else if (EN) begin
      w_load = 1'b1;
      if (r_dwell == DWELL_CNT) begin
        w_dwell_nxt = DWELL_ONE;
        w_ch_nxt    = (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
        w_wrap_nxt  = (r_ch == LAST_CH);
      end else begin
        w_dwell_nxt = r_dwell + 1'b1;
      end
    end

    w_valid_nxt = w_load;
    if (w_load) begin
      w_y_nxt = w_ch_data[w_ch_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_wrap  <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_ch    <= w_ch_nxt;
      r_wrap  <= w_wrap_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  assign Y       = r_y;
  assign Y_VALID = r_valid;
  assign CH      = r_ch;
  assign WRAP    = r_wrap;

`ifdef TDM_MUX_PARITY_EN
  logic r_y_par;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_y_par <= 1'b0;
    end else if (w_load) begin
      r_y_par <= ^w_y_nxt;
    end
  end

  assign Y_PAR = r_y_par;
`else
  // Parity output not built in this configuration.
`endif

endmodule

// File: tb/tb_tdm_mux_seq.sv
// Scoreboard bench for tdm_mux_seq: three instances cover DWELL=2, DWELL=1 and N=3.
module tb_tdm_mux_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic [1:0] ch;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Instance A: N=4, W=8, DWELL=2
  logic        a_rst, a_mode, a_en;
  logic [31:0] a_d;
  logic [1:0]  a_sel, a_ch;
  logic [7:0]  a_y;
  logic        a_v, a_wrap, a_par;
  // Instance B: N=4, W=8, DWELL=1
  logic        b_rst, b_mode, b_en;
  logic [31:0] b_d;
  logic [1:0]  b_sel, b_ch;
  logic [7:0]  b_y;
  logic        b_v, b_wrap, b_par;
  // Instance C: N=3, W=8, DWELL=1
  logic        c_rst, c_mode, c_en;
  logic [23:0] c_d;
  logic [1:0]  c_sel, c_ch;
  logic [7:0]  c_y;
  logic        c_v, c_wrap, c_par;

  tdm_mux_seq #(.N(4), .W(8), .DWELL(2)) u_dut_a (
    .CLK(CLK), .RST(a_rst), .D(a_d), .SEL(a_sel), .MODE(a_mode), .EN(a_en),
    .Y(a_y), .Y_VALID(a_v), .CH(a_ch), .WRAP(a_wrap)
`ifdef TDM_MUX_PARITY_EN
    , .Y_PAR(a_par)
`endif
  );

  tdm_mux_seq #(.N(4), .W(8), .DWELL(1)) u_dut_b (
    .CLK(CLK), .RST(b_rst), .D(b_d), .SEL(b_sel), .MODE(b_mode), .EN(b_en),
    .Y(b_y), .Y_VALID(b_v), .CH(b_ch), .WRAP(b_wrap)
`ifdef TDM_MUX_PARITY_EN
    , .Y_PAR(b_par)
`endif
  );

  tdm_mux_seq #(.N(3), .W(8), .DWELL(1)) u_dut_c (
    .CLK(CLK), .RST(c_rst), .D(c_d), .SEL(c_sel), .MODE(c_mode), .EN(c_en),
    .Y(c_y), .Y_VALID(c_v), .CH(c_ch), .WRAP(c_wrap)
`ifdef TDM_MUX_PARITY_EN
    , .Y_PAR(c_par)
`endif
  );

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int idx);
    return d[idx*8 +: 8];
  endfunction

  task automatic test_reset();
    a_d = 32'hDDCC_BBAA; a_rst = 1'b1; a_mode = 1'b0; a_en = 1'b1; a_sel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{y: 8'h00, v: 1'b0, ch: 2'd0, wrap: 1'b0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({a_y, a_v, a_ch, a_wrap} !== e) begin
        errors++;
        $display("FAIL reset[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, a_y, a_v, a_ch, a_wrap, e.y, e.v, e.ch, e.wrap);
      end
    end
    a_rst = 1'b0;
  endtask

  task automatic test_manual();
    a_mode = 1'b0; a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      sb.push_back('{y: byte_of(a_d, i), v: 1'b1, ch: 2'(i), wrap: 1'b0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({a_y, a_v, a_ch, a_wrap} !== e) begin
        errors++;
        $display("FAIL manual[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, a_y, a_v, a_ch, a_wrap, e.y, e.v, e.ch, e.wrap);
      end
    end
  endtask

  // DWELL=2 sweep; D changes mid-scan to confirm Y tracks live data.
  task automatic test_scan();
    int ch_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    a_mode = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_d = (i < 5) ? 32'hDDCC_BBAA : 32'h4433_2211;
      sb.push_back('{y: byte_of(a_d, ch_seq[i]), v: 1'b1, ch: 2'(ch_seq[i]), wrap: (i == 8)});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({a_y, a_v, a_ch, a_wrap} !== e) begin
        errors++;
        $display("FAIL scan[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, a_y, a_v, a_ch, a_wrap, e.y, e.v, e.ch, e.wrap);
      end
    end
  endtask

  // Continues the sweep to CH=3, resets with MODE still high, then exercises mode switches.
  task automatic test_reset_midscan();
    logic       rst_t  [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic       mode_t [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [1:0] sel_t  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1};
    logic [31:0] d_t   [13];
    int          ch_t  [13] = '{1, 1, 2, 2, 3, 0, 0, 0, 1, 2, 0, 0, 1};
    for (int i = 0; i < 13; i++) d_t[i] = (i < 5) ? 32'h4433_2211 : 32'hDDCC_BBAA;
    a_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      a_rst = rst_t[i]; a_mode = mode_t[i]; a_sel = sel_t[i]; a_d = d_t[i];
      if (rst_t[i])
        sb.push_back('{y: 8'h00, v: 1'b0, ch: 2'd0, wrap: 1'b0});
      else
        sb.push_back('{y: byte_of(d_t[i], ch_t[i]), v: 1'b1, ch: 2'(ch_t[i]), wrap: 1'b0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({a_y, a_v, a_ch, a_wrap} !== e) begin
        errors++;
        $display("FAIL midscan[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, a_y, a_v, a_ch, a_wrap, e.y, e.v, e.ch, e.wrap);
      end
    end
    a_rst = 1'b0;
  endtask

  task automatic test_en_gating();
    logic en_t [9] = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
    int   ch_t [9] = '{0, 0, 1, 2, 2, 2, 2, 3, 0};
    b_d = 32'hDDCC_BBAA; b_sel = 2'd0;
    for (int i = 0; i < 9; i++) begin
      b_rst = (i == 0); b_mode = (i != 0); b_en = en_t[i];
      if (i == 0)
        sb.push_back('{y: 8'h00, v: 1'b0, ch: 2'd0, wrap: 1'b0});
      else
        sb.push_back('{y: byte_of(b_d, ch_t[i]), v: en_t[i], ch: 2'(ch_t[i]), wrap: (i == 8)});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({b_y, b_v, b_ch, b_wrap} !== e) begin
        errors++;
        $display("FAIL en_gate[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, b_y, b_v, b_ch, b_wrap, e.y, e.v, e.ch, e.wrap);
      end
    end
  endtask

  // N=3: SEL=3 must hold CH/Y and drop Y_VALID; parity follows the held Y.
  task automatic test_out_of_range();
    logic [1:0] sel_t [7] = '{0, 0, 1, 3, 2, 3, 0};
    logic       en_t  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [7:0] y_t   [7] = '{8'h00, 8'h07, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hCC};
    logic       v_t   [7] = '{0, 1, 1, 0, 1, 0, 0};
    int         ch_t  [7] = '{0, 0, 1, 1, 2, 2, 2};
    c_d = 24'hCC_BB_07; c_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      c_rst = (i == 0); c_sel = sel_t[i]; c_en = en_t[i];
      sb.push_back('{y: y_t[i], v: v_t[i], ch: 2'(ch_t[i]), wrap: 1'b0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({c_y, c_v, c_ch, c_wrap} !== e) begin
        errors++;
        $display("FAIL out_of_range[%0d] got y=%h v=%b ch=%0d wrap=%b exp y=%h v=%b ch=%0d wrap=%b",
                 i, c_y, c_v, c_ch, c_wrap, e.y, e.v, e.ch, e.wrap);
      end
`ifdef TDM_MUX_PARITY_EN
      checks++;
      if (c_par !== ^e.y) begin
        errors++;
        $display("FAIL parity[%0d] got %b exp %b", i, c_par, ^e.y);
      end
`endif
    end
    c_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_mode = 1'b0; a_en = 1'b0; a_sel = '0; a_d = '0;
    b_rst = 1'b1; b_mode = 1'b0; b_en = 1'b0; b_sel = '0; b_d = '0;
    c_rst = 1'b1; c_mode = 1'b0; c_en = 1'b0; c_sel = '0; c_d = '0;
    @(negedge CLK);
    test_reset();
    test_manual();
    test_scan();
    test_reset_midscan();
    test_en_gating();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
